// File: rtl/sram_cfg_loader.sv
// rtl/sram_cfg_loader.sv - byte-serial bitstream loader writing frames into SRAM config rows
module sram_cfg_loader #(
    parameter int FRAME_WIDTH = 32,
    parameter int NUM_FRAMES  = 64,
    parameter int WL_PULSE    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          cfg_valid,
    input  logic [7:0]                    cfg_data,
    output logic                          cfg_ready,
    output logic                          bl_en,
    output logic [FRAME_WIDTH-1:0]        bl_data,
    output logic [FRAME_WIDTH-1:0]        bl_data_n,
    output logic [NUM_FRAMES-1:0]         wl_en,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int BPF  = FRAME_WIDTH / 8;
    localparam int FI_W = $clog2(NUM_FRAMES);
    localparam int BC_W = $clog2(BPF + 1);
    localparam int PC_W = $clog2(WL_PULSE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t                 state, state_nx;
    logic [FRAME_WIDTH-1:0] frame_buf, frame_buf_nx;
    logic [7:0]             sum, sum_nx, sum_plus;
    logic [BC_W-1:0]        byte_cnt, byte_cnt_nx;
    logic [PC_W-1:0]        pulse_cnt, pulse_cnt_nx;
    logic [FI_W-1:0]        frame_idx_nx;

    logic                   cfg_ready_nx;
    logic                   bl_en_nx;
    logic [FRAME_WIDTH-1:0] bl_data_nx;
    logic [FRAME_WIDTH-1:0] bl_data_n_nx;
    logic [NUM_FRAMES-1:0]  wl_en_nx;
    logic                   busy_nx;
    logic                   done_nx;
    logic                   err_nx;
    logic                   xfer;

    // State, datapath and registered outputs; every output is a flop so the
    // bitline/word-line drivers never see combinational glitches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            frame_buf <= '0;
            sum       <= '0;
            byte_cnt  <= '0;
            pulse_cnt <= '0;
            frame_idx <= '0;
            cfg_ready <= 1'b0;
            bl_en     <= 1'b0;
            bl_data   <= '0;
            bl_data_n <= '0;
            wl_en     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_buf <= frame_buf_nx;
            sum       <= sum_nx;
            byte_cnt  <= byte_cnt_nx;
            pulse_cnt <= pulse_cnt_nx;
            frame_idx <= frame_idx_nx;
            cfg_ready <= cfg_ready_nx;
            bl_en     <= bl_en_nx;
            bl_data   <= bl_data_nx;
            bl_data_n <= bl_data_n_nx;
            wl_en     <= wl_en_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
        end
    end

    // Next-state and datapath updates; output values are decoded from the
    // next state so they line up with the state they describe.
    always_comb begin
        state_nx     = state;
        frame_buf_nx = frame_buf;
        sum_nx       = sum;
        byte_cnt_nx  = byte_cnt;
        pulse_cnt_nx = pulse_cnt;
        frame_idx_nx = frame_idx;
        xfer         = cfg_valid && cfg_ready;
        sum_plus     = sum + cfg_data;

        if (abort) begin
            // Abort wins over everything except reset; nothing is consumed
            // and already-written rows stay as they are.
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_nx     = S_LOAD;
                        frame_idx_nx = '0;
                        byte_cnt_nx  = '0;
                        sum_nx       = '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        for (int k = 0; k < BPF; k++) begin
                            if (byte_cnt == BC_W'(k)) begin
                                frame_buf_nx[8*k +: 8] = cfg_data;
                            end
                        end
                        sum_nx = sum_plus;
                        if (byte_cnt == BC_W'(BPF - 1)) begin
                            state_nx    = S_SETUP;
                            byte_cnt_nx = '0;
                        end else begin
                            byte_cnt_nx = byte_cnt + BC_W'(1);
                        end
                    end
                end
                S_SETUP: begin
                    state_nx     = S_PULSE;
                    pulse_cnt_nx = '0;
                end
                S_PULSE: begin
                    if (pulse_cnt == PC_W'(WL_PULSE - 1)) begin
                        state_nx = S_HOLD;
                    end else begin
                        pulse_cnt_nx = pulse_cnt + PC_W'(1);
                    end
                end
                S_HOLD: begin
                    if (frame_idx == FI_W'(NUM_FRAMES - 1)) begin
                        state_nx = S_CHECK;
                    end else begin
                        state_nx     = S_LOAD;
                        frame_idx_nx = frame_idx + FI_W'(1);
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        state_nx = (sum_plus == 8'h00) ? S_DONE : S_ERR;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end

        cfg_ready_nx = (state_nx == S_LOAD) || (state_nx == S_CHECK);
        bl_en_nx     = (state_nx == S_SETUP) || (state_nx == S_PULSE) || (state_nx == S_HOLD);
        bl_data_nx   = bl_en_nx ? frame_buf_nx : '0;
        bl_data_n_nx = bl_en_nx ? ~frame_buf_nx : '0;
        wl_en_nx     = '0;
        if (state_nx == S_PULSE) begin
            wl_en_nx[frame_idx_nx] = 1'b1;
        end
        busy_nx = (state_nx == S_LOAD) || (state_nx == S_SETUP) || (state_nx == S_PULSE) ||
                  (state_nx == S_HOLD) || (state_nx == S_CHECK);
        done_nx = (state_nx == S_DONE);
        err_nx  = (state_nx == S_ERR);
    end

endmodule

// File: tb/tb_sram_cfg_loader.sv
// tb/tb_sram_cfg_loader.sv - self-checking bench for sram_cfg_loader
module tb_sram_cfg_loader;

    localparam int FW = 16;
    localparam int NF = 4;
    localparam int WL = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [7:0]    cfg_data = 8'h00;
    logic          cfg_ready;
    logic          bl_en;
    logic [FW-1:0] bl_data;
    logic [FW-1:0] bl_data_n;
    logic [NF-1:0] wl_en;
    logic [1:0]    frame_idx;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad = 0;

    logic [7:0]  vec [9];
    logic [15:0] obs_mem [NF];
    int          obs_cnt [NF];
    logic [7:0]  acc_q [$];

    sram_cfg_loader #(.FRAME_WIDTH(FW), .NUM_FRAMES(NF), .WL_PULSE(WL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .bl_en(bl_en), .bl_data(bl_data), .bl_data_n(bl_data_n), .wl_en(wl_en),
        .frame_idx(frame_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: row r holds bytes 2r (low) and 2r+1 (high); load is good when
    // all nine bytes sum to zero modulo 256.
    function automatic logic [15:0] exp_row(input int r);
        return {vec[2*r+1], vec[2*r]};
    endfunction

    function automatic bit exp_good();
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(vec[i]);
        return (s % 256) == 0;
    endfunction

    // Per-cycle checker: invariants, pulse framing, observed row writes and bytes consumed.
    logic          prev_bl_en = 1'b0;
    logic          prev2_bl_en = 1'b0;
    logic [15:0]   prev_bl_data = '0;
    logic [NF-1:0] prev_wl = '0;
    int            plen = 0;
    int            prow = 0;
    bit            hold_chk = 0;
    bit            dist_prev = 0;
    bit            dist_was_reset = 0;

    always @(negedge clk) begin
        if (dist_prev) begin
            chk("ctl_wl", wl_en, 0);
            chk("ctl_bl_en", bl_en, 0);
            chk("ctl_bl_data", bl_data, 0);
            chk("ctl_busy", busy, 0);
            chk("ctl_done", done, 0);
            chk("ctl_err", err, 0);
            chk("ctl_ready", cfg_ready, 0);
            if (dist_was_reset) chk("rst_fidx", frame_idx, 0);
            plen = 0;
            hold_chk = 0;
        end else begin
            chk("wl_onehot", $countones(wl_en) <= 1, 1);
            if (bl_en) begin
                chk("bl_inverse", bl_data_n, 16'(~bl_data));
                chk("ready_in_write", cfg_ready, 0);
            end else begin
                chk("bl_idle_zero", {bl_data, bl_data_n}, 0);
                chk("wl_needs_bl", wl_en, 0);
            end
            if (hold_chk) begin
                chk("hold_one_cycle", bl_en, 0);
                hold_chk = 0;
            end
            if (wl_en != 0) begin
                if (prev_wl == 0) begin
                    chk("setup_bl_en", prev_bl_en, 1);
                    chk("setup_data", prev_bl_data, bl_data);
                    chk("setup_one_cycle", prev2_bl_en, 0);
                    plen = 1;
                    for (int k = 0; k < NF; k++) if (wl_en[k]) prow = k;
                end else begin
                    chk("wl_stable", wl_en, prev_wl);
                    chk("pulse_data", bl_data, prev_bl_data);
                    plen++;
                end
                chk("wl_row", wl_en, 4'(4'b0001 << frame_idx));
            end else if (prev_wl != 0 && plen > 0) begin
                chk("pulse_len", plen, WL);
                chk("hold_bl_en", bl_en, 1);
                chk("hold_data", bl_data, prev_bl_data);
                obs_mem[prow] = prev_bl_data;
                obs_cnt[prow]++;
                hold_chk = 1;
                plen = 0;
            end
        end
        if (reset_n && !abort && cfg_valid && cfg_ready) acc_q.push_back(cfg_data);
        dist_was_reset = !reset_n;
        dist_prev = !reset_n || abort;
        prev2_bl_en = prev_bl_en;
        prev_bl_en = bl_en;
        prev_bl_data = bl_data;
        prev_wl = wl_en;
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int g = 0;
        bit ok = 0;
        cfg_data = b;
        while (g < 300) begin
            cfg_valid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            @(negedge clk);
            if (cfg_valid && cfg_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            g++;
        end
        chk("byte_accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_load(input bit rnd, input int glitch);
        int g = 0;
        for (int r = 0; r < NF; r++) begin
            obs_mem[r] = '0;
            obs_cnt[r] = 0;
        end
        acc_q.delete();
        start_pulse();
        chk("load_busy", busy, 1);
        chk("load_ready", cfg_ready, 1);
        chk("load_fidx", frame_idx, 0);
        chk("load_done_clr", done, 0);
        chk("load_err_clr", err, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == glitch) start_pulse();
            send_byte(vec[i], rnd);
        end
        while (busy && g < 50) begin
            tick();
            g++;
        end
        chk("end_busy", busy, 0);
        chk("end_done", done, exp_good());
        chk("end_err", err, !exp_good());
        for (int r = 0; r < NF; r++) begin
            chk("row_data", obs_mem[r], exp_row(r));
            chk("row_writes", obs_cnt[r], 1);
        end
        chk("bytes_consumed", acc_q.size(), 9);
        for (int i = 0; i < 9 && i < acc_q.size(); i++) chk("byte_order", acc_q[i], vec[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        repeat (2) tick();
        chk("rst_ready", cfg_ready, 0);
        chk("rst_bl_en", bl_en, 0);
        chk("rst_bl", {bl_data, bl_data_n}, 0);
        chk("rst_wl", wl_en, 0);
        chk("rst_fidx0", frame_idx, 0);
        chk("rst_flags", {busy, done, err}, 0);
        reset_n = 1'b1;
        tick();

        // 1: good checksum
        vec = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hDC};
        chk("model_good_t1", exp_good(), 1);
        chk("model_row3_t1", exp_row(3), 16'h0807);
        run_load(0, -1);
        chk("t1_row0_lit", obs_mem[0], 16'h0201);
        chk("t1_row1_lit", obs_mem[1], 16'h0403);
        chk("t1_row3_lit", obs_mem[3], 16'h0807);
        chk("t1_done_lit", {done, err, busy}, 3'b100);

        // 2: bad checksum, then start clears err
        vec[8] = 8'h00;
        chk("model_good_t2", exp_good(), 0);
        run_load(0, -1);
        chk("t2_flags_lit", {done, err}, 2'b01);
        start_pulse();
        chk("t2_err_cleared", err, 0);
        chk("t2_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t2_abort_idle", busy, 0);

        // 3: random cfg_valid
        vec[8] = 8'hDC;
        run_load(1, -1);
        chk("t3_row2_lit", obs_mem[2], 16'h0605);

        // 4: abort during row 2 pulse, then restart
        start_pulse();
        for (int i = 0; i < 6; i++) send_byte(vec[i], 0);
        g = 0;
        @(negedge clk);
        while (!wl_en[2] && g < 40) begin
            g++;
            @(negedge clk);
        end
        chk("t4_reach_row2", wl_en[2], 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t4_wl_off", wl_en, 0);
        chk("t4_bl_off", bl_en, 0);
        chk("t4_idle", {busy, done, err, cfg_ready}, 0);
        tick();
        chk("t4_stay_idle", busy, 0);
        run_load(0, -1);

        // 5: reset mid-load, start ignored while busy, restart from DONE
        start_pulse();
        for (int i = 0; i < 3; i++) send_byte(vec[i], 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t5_rst_flags", {busy, done, err, cfg_ready, bl_en}, 0);
        chk("t5_rst_bl", {bl_data, bl_data_n}, 0);
        chk("t5_rst_wl", wl_en, 0);
        chk("t5_rst_fidx", frame_idx, 0);
        tick();
        run_load(0, 3);
        chk("t5_done_first", done, 1);
        vec = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h80, 8'h7F, 8'hBD};
        chk("model_good_t5", exp_good(), 1);
        run_load(0, -1);
        chk("t5_row0_lit", obs_mem[0], 16'h5AA5);
        chk("t5_row3_lit", obs_mem[3], 16'h7F80);
        chk("t5_done_second", done, 1);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
